// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain arbiter: pops one flit per grant from N input FIFOs into a
// single valid/ready output register, with per-port enables and a saturating forward counter.
module fifo_rr_drain_arbiter #(
  parameter int N      = 5,
  parameter int DATA_W = 16,
  parameter int PTR_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        fifo_empty,
  input  logic [N*DATA_W-1:0] fifo_data,
  output logic [N-1:0]        fifo_read,
  input  logic [N-1:0]        port_en,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready,
  output logic [PTR_W-1:0]    grant_id,
  output logic [CNT_W-1:0]    fwd_count
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PTR_W-1:0]  gid_q, gid_d;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [N-1:0]      req;
  logic [PTR_W-1:0]  ptr_eff;
  logic [PTR_W-1:0]  g;
  logic [PTR_W-1:0]  idx_p;
  logic              found;
  logic              load_ok;
  logic              grant;
  int                idx;

  assign req     = ~fifo_empty & port_en;
  assign load_ok = ~valid_q | out_ready;

  // An out-of-range pointer (never reached in normal operation) restarts the search at 0.
  assign ptr_eff = (int'(rr_ptr_q) < N) ? rr_ptr_q : '0;

  always_comb begin
    found = 1'b0;
    g     = '0;
    idx   = 0;
    idx_p = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_eff) + k;
      if (idx >= N) idx = idx - N;
      idx_p = PTR_W'(idx);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        g     = idx_p;
      end
    end
  end

  // Reset gates the strobe so no FIFO pops while the output register is being cleared.
  assign grant = reset & load_ok & found;

  always_comb begin
    fifo_read = '0;
    if (grant) fifo_read[g] = 1'b1;
  end

  always_comb begin
    valid_d  = valid_q;
    data_d   = data_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
    if (grant) begin
      valid_d  = 1'b1;
      data_d   = fifo_data[int'(g)*DATA_W +: DATA_W];
      gid_d    = g;
      rr_ptr_d = (int'(g) == N-1) ? '0 : g + 1'b1;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      data_q   <= '0;
      gid_q    <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign grant_id  = gid_q;
  assign fwd_count = cnt_q;

endmodule

// File: tb/tb_fifo_rr_drain_arbiter.sv
// Bench for fifo_rr_drain_arbiter: emulated FIFOs, queue-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_fifo_rr_drain_arbiter;
  localparam int N  = 5;
  localparam int DW = 16;
  localparam int PW = 3;
  localparam int CW = 5;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    fifo_empty;
  logic [N*DW-1:0] fifo_data;
  logic [N-1:0]    fifo_read;
  logic [N-1:0]    port_en;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_ready;
  logic [PW-1:0]   grant_id;
  logic [CW-1:0]   fwd_count;

  fifo_rr_drain_arbiter #(.N(N), .DATA_W(DW), .PTR_W(PW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .port_en(port_en), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .grant_id(grant_id),
    .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // emulated input FIFOs as circular buffers
  logic [DW-1:0] fbuf [N][32];
  int rd [N];
  int wr [N];

  // reference model: what the link side must show
  bit            m_valid;
  logic [DW-1:0] m_data;
  int            m_gid, m_ptr, m_cnt;

  logic [DW-1:0] seen [$];
  logic [DW-1:0] exp_seq [$];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int depth(input int i);
    return wr[i] - rd[i];
  endfunction

  task automatic drive_fifos();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (wr[i] == rd[i]);
      fifo_data[i*DW +: DW] = fbuf[i][rd[i] % 32];
    end
  endtask

  task automatic push(input int i, input logic [DW-1:0] v);
    if (depth(i) < 32) begin
      fbuf[i][wr[i] % 32] = v;
      wr[i]++;
    end
    drive_fifos();
  endtask

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_gid = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock: check at negedge against the model, advance the model at posedge.
  task automatic cycle();
    int g;
    bit gr;
    logic [N-1:0] exp_rd;
    @(negedge clk);
    exp_rd = '0; gr = 0; g = 0;
    if (reset && (!m_valid || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!gr && depth(p) > 0 && port_en[p]) begin gr = 1; g = p; end
      end
      if (gr) exp_rd[g] = 1'b1;
    end
    check("fifo_read", 32'(fifo_read), 32'(exp_rd));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("grant_id",  32'(grant_id),  m_gid);
    check("fwd_count", 32'(fwd_count), m_cnt);
    if (out_valid && out_ready) seen.push_back(out_data);
    @(posedge clk);
    if (reset) begin
      if (m_valid && out_ready && m_cnt < CMAX) m_cnt++;
      if (gr) begin
        m_data = fbuf[g][rd[g] % 32];
        rd[g]++;
        m_valid = 1; m_gid = g; m_ptr = (g + 1) % N;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
    end
    #1;
    drive_fifos();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Asynchronous reset pulse between edges; must clear outputs with no clock edge.
  task automatic mid_reset();
    #3;
    reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 0);
    check("async_rst_cnt",   32'(fwd_count), 0);
    check("async_rst_read",  32'(fifo_read), 0);
    model_reset();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin rd[i] = 0; wr[i] = 0; end
    reset = 1'b0; out_ready = 1'b1; port_en = '1;
    model_reset();
    drive_fifos();
    #12;
    check("reset_valid", 32'(out_valid), 0);
    check("reset_cnt",   32'(fwd_count), 0);
    check("reset_gid",   32'(grant_id), 0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 1: idle with empty FIFOs
    run(10);
    check("idle_cnt", 32'(fwd_count), 0);

    // 2: two flits per port, full-rate drain in round-robin order
    for (int i = 0; i < N; i++) begin
      push(i, DW'(16*i + 1));
      push(i, DW'(16*i + 2));
    end
    seen.delete();
    run(12);
    exp_seq = '{16'h01, 16'h11, 16'h21, 16'h31, 16'h41, 16'h02, 16'h12, 16'h22, 16'h32, 16'h42};
    check("t2_len", seen.size(), 10);
    for (int k = 0; k < 10 && k < seen.size(); k++) check("t2_seq", 32'(seen[k]), 32'(exp_seq[k]));
    check("t2_cnt", 32'(fwd_count), 10);
    check("t2_gid", 32'(grant_id), 4);

    // 3: only ports 1 and 3, pointer parked at 2
    push(1, 16'h0077);
    run(2);
    push(1, 16'h00A1); push(1, 16'h00A2); push(1, 16'h00A3);
    push(3, 16'h00C1); push(3, 16'h00C2); push(3, 16'h00C3);
    seen.delete();
    for (int k = 0; k < 8; k++) begin
      check("t3_read_mask", 32'(fifo_read & 5'b10101), 0);
      cycle();
    end
    exp_seq = '{16'h00C1, 16'h00A1, 16'h00C2, 16'h00A2, 16'h00C3, 16'h00A3};
    check("t3_len", seen.size(), 6);
    for (int k = 0; k < 6 && k < seen.size(); k++) check("t3_seq", 32'(seen[k]), 32'(exp_seq[k]));

    // 4: back-pressure holds the register, release refills on the same edge
    out_ready = 1'b0;
    push(0, 16'h00AB); push(0, 16'h00CD);
    cycle();
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t4_hold_data",  32'(out_data), 32'h00AB);
      check("t4_hold_valid", 32'(out_valid), 1);
      check("t4_hold_read",  32'(fifo_read), 0);
    end
    check("t4_cnt_before", 32'(fwd_count), 17);
    out_ready = 1'b1;
    cycle();
    check("t4_refill_data", 32'(out_data), 32'h00CD);
    check("t4_cnt_after",   32'(fwd_count), 18);
    run(2);

    // 5: disabled port is never popped, re-enabling admits it
    port_en = 5'b11101;
    push(1, 16'h0051); push(1, 16'h0052); push(3, 16'h0053);
    run(5);
    check("t5_port1_kept", depth(1), 2);
    check("t5_port3_done", depth(3), 0);
    port_en = 5'b11111;
    run(5);
    check("t5_port1_done", depth(1), 0);

    // 6: counter saturation, then async reset mid-stream
    mid_reset();
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < N; i++) push(i, DW'(16'h0100 + 16*i + k));
    run(45);
    check("t6_saturated", 32'(fwd_count), CMAX);
    push(2, 16'h0222); push(4, 16'h0444);
    run(1);
    check("t6_busy", 32'(out_valid), 1);
    mid_reset();
    run(4);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) push(i, DW'($urandom));
      if ($urandom_range(0, 7) == 0) port_en = N'($urandom);
      else if ($urandom_range(0, 3) == 0) port_en = '1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (c == 250) mid_reset();
      else cycle();
    end
    port_en = '1; out_ready = 1'b1;
    run(200);
    for (int i = 0; i < N; i++) check("final_drained", depth(i), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
